// File: rtl/modo_sel.sv
// Purpose : picks which memory-mapping engine drives the ROM/EEPROM/SRAM pins; mode changes are applied only at a safe point.
// Latency : outputs follow inputs combinationally; a mode write takes effect SETTLE+1 clocks or more after it is accepted.
// Backpr. : none. A write that arrives while a change is in flight, or after lock is set, is dropped.
//
// Ports:
//   clk, mrst_n                      clock and asynchronous active-low reset
//   zxuno_addr/regrd/regwr, d        ZX-Uno register port (d is driven only while ADDR_MODO is read)
//   cpu_mreq_n                       CPU memory request; high means the bus is idle and a change may start
//   allramplus3                      +3 all-RAM override; forces every strobe inactive and a fixed high address
//   src_*                            per-source strobes and high address; source i uses bit i and slice [i*HIW +: HIW]
//   zxromcs, eeprom_oe_n, sram_oe_n,
//   sram_write_n, sram_hiaddr        physical memory controls
//   busy                             a mode change is in progress
module modo_sel #(
  parameter logic [7:0]     ADDR_MODO = 8'hDF,
  parameter int             NSRC      = 3,
  parameter int             HIW       = 6,
  parameter int             SETTLE    = 4,
  parameter logic [HIW-1:0] PLUS3_HI  = 6'b110000
) (
  input  logic                clk,
  input  logic                mrst_n,
  input  logic [7:0]          zxuno_addr,
  input  logic                zxuno_regrd,
  input  logic                zxuno_regwr,
  inout  wire  [7:0]          d,
  input  logic                cpu_mreq_n,
  input  logic                allramplus3,
  input  logic [NSRC-1:0]     src_active,
  input  logic [NSRC-1:0]     src_zxromcs,
  input  logic [NSRC-1:0]     src_eeprom_cs,
  input  logic [NSRC-1:0]     src_sram_cs,
  input  logic [NSRC-1:0]     src_sram_write_n,
  input  logic [NSRC*HIW-1:0] src_sram_hiaddr,
  output logic                zxromcs,
  output logic                eeprom_oe_n,
  output logic                sram_oe_n,
  output logic                sram_write_n,
  output logic [HIW-1:0]      sram_hiaddr,
  output logic                busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;

  localparam logic [2:0] NSRC_W    = 3'(NSRC);
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

  logic [1:0] state;
  logic [3:0] cnt;
  logic [1:0] sel, psel;
  logic       ovl, povl;
  logic       lock, plock;
  logic       regwr_q;

  logic       addr_hit;
  logic       wr_acc;
  logic       sel_ok;
  logic [7:0] rd_dat;
  logic       unused_d;

  assign addr_hit = (zxuno_addr == ADDR_MODO);
  // Only the rising edge of regwr counts, so a strobe held across the
  // commit point cannot be taken a second time.
  assign wr_acc   = zxuno_regwr && !regwr_q && addr_hit && (state == ST_IDLE) && !lock;
  // An out-of-range select leaves sel alone but still updates ovl and lock.
  assign sel_ok   = ({1'b0, d[1:0]} < NSRC_W);
  assign busy     = (state != ST_IDLE);
  assign rd_dat   = {lock, ovl, busy, 3'b000, sel};
  assign d        = (zxuno_regrd && addr_hit) ? rd_dat : 8'bz;
  assign unused_d = ^d[5:2];

  always_ff @(posedge clk or negedge mrst_n) begin
    if (!mrst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      sel     <= '0;
      psel    <= '0;
      ovl     <= 1'b0;
      povl    <= 1'b0;
      lock    <= 1'b0;
      plock   <= 1'b0;
      regwr_q <= 1'b0;
    end else begin
      regwr_q <= zxuno_regwr;
      case (state)
        ST_IDLE: begin
          if (wr_acc) begin
            psel  <= sel_ok ? d[1:0] : sel;
            povl  <= d[6];
            plock <= d[7];
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // No timeout: the change waits as long as the CPU keeps the bus busy.
          if (cpu_mreq_n) begin
            state <= ST_SETTLE;
            cnt   <= SETTLE_LD;
          end
        end
        ST_SETTLE: begin
          if (cnt == 4'd0) begin
            sel   <= psel;
            ovl   <= povl;
            lock  <= plock;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic [1:0]     src_idx;
  logic           m_zx, m_ee, m_sr, m_wn;
  logic [HIW-1:0] m_hi;

  always_comb begin
    // Overlay lets source 0 take over whenever it pages itself in.
    src_idx = (ovl && src_active[0]) ? 2'd0 : sel;
    m_zx    = 1'b0;
    m_ee    = 1'b0;
    m_sr    = 1'b0;
    m_wn    = 1'b1;
    m_hi    = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (src_idx == 2'(i)) begin
        m_zx = src_zxromcs[i];
        m_ee = src_eeprom_cs[i];
        m_sr = src_sram_cs[i];
        m_wn = src_sram_write_n[i];
        m_hi = src_sram_hiaddr[i*HIW +: HIW];
      end
    end

    zxromcs      = m_zx;
    eeprom_oe_n  = ~m_ee;
    sram_oe_n    = ~m_sr;
    sram_write_n = m_wn;
    sram_hiaddr  = m_hi;

    if (allramplus3) begin
      zxromcs      = 1'b0;
      eeprom_oe_n  = 1'b1;
      sram_oe_n    = 1'b1;
      sram_write_n = 1'b1;
      sram_hiaddr  = PLUS3_HI;
    end else if (state == ST_SETTLE) begin
      // Strobes are blanked while the mode settles; the high address stays
      // on the old source so the address pins do not glitch.
      zxromcs      = 1'b0;
      eeprom_oe_n  = 1'b1;
      sram_oe_n    = 1'b1;
      sram_write_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_modo_sel.sv
module tb_modo_sel;

  logic        clk = 1'b0;
  logic        mrst_n;
  logic [7:0]  zxuno_addr;
  logic        zxuno_regrd;
  logic        zxuno_regwr;
  wire  [7:0]  d;
  logic [7:0]  d_drv;
  logic        d_en;
  logic        cpu_mreq_n;
  logic        allramplus3;
  logic [2:0]  src_active;
  logic [2:0]  src_zxromcs;
  logic [2:0]  src_eeprom_cs;
  logic [2:0]  src_sram_cs;
  logic [2:0]  src_sram_write_n;
  logic [17:0] src_sram_hiaddr;
  logic        zxromcs, eeprom_oe_n, sram_oe_n, sram_write_n, busy;
  logic [5:0]  sram_hiaddr;

  assign d = d_en ? d_drv : 8'bz;

  modo_sel dut (
    .clk              (clk),
    .mrst_n           (mrst_n),
    .zxuno_addr       (zxuno_addr),
    .zxuno_regrd      (zxuno_regrd),
    .zxuno_regwr      (zxuno_regwr),
    .d                (d),
    .cpu_mreq_n       (cpu_mreq_n),
    .allramplus3      (allramplus3),
    .src_active       (src_active),
    .src_zxromcs      (src_zxromcs),
    .src_eeprom_cs    (src_eeprom_cs),
    .src_sram_cs      (src_sram_cs),
    .src_sram_write_n (src_sram_write_n),
    .src_sram_hiaddr  (src_sram_hiaddr),
    .zxromcs          (zxromcs),
    .eeprom_oe_n      (eeprom_oe_n),
    .sram_oe_n        (sram_oe_n),
    .sram_write_n     (sram_write_n),
    .sram_hiaddr      (sram_hiaddr),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  task automatic sb_push(input string tag, input logic [31:0] val);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_underflow observed=%0h", obs);
      return;
    end
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
    end
  endtask

  function automatic logic [31:0] exp_src(input int i);
    return {22'd0, src_zxromcs[i], ~src_eeprom_cs[i], ~src_sram_cs[i],
            src_sram_write_n[i], src_sram_hiaddr[i*6 +: 6]};
  endfunction

  function automatic logic [31:0] exp_blank(input logic [5:0] hi);
    return {22'd0, 1'b0, 1'b1, 1'b1, 1'b1, hi};
  endfunction

  function automatic logic [31:0] obs_out();
    return {22'd0, zxromcs, eeprom_oe_n, sram_oe_n, sram_write_n, sram_hiaddr};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] v);
    zxuno_addr  = 8'hDF;
    d_drv       = v;
    d_en        = 1'b1;
    zxuno_regwr = 1'b1;
    tick();
    zxuno_regwr = 1'b0;
    d_en        = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [7:0] expv);
    zxuno_addr  = 8'hDF;
    zxuno_regrd = 1'b1;
    #1;
    sb_push(tag, {24'd0, expv});
    sb_check({24'd0, d});
    zxuno_regrd = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] expv);
    sb_push(tag, expv);
    sb_check(obs_out());
  endtask

  task automatic chk_busy(input string tag, input logic expv);
    sb_push(tag, {31'd0, expv});
    sb_check({31'd0, busy});
  endtask

  initial begin
    mrst_n           = 1'b0;
    zxuno_addr       = 8'h00;
    zxuno_regrd      = 1'b0;
    zxuno_regwr      = 1'b0;
    d_drv            = 8'h00;
    d_en             = 1'b0;
    cpu_mreq_n       = 1'b1;
    allramplus3      = 1'b0;
    src_active       = 3'b000;
    src_zxromcs      = 3'b001;
    src_eeprom_cs    = 3'b010;
    src_sram_cs      = 3'b101;
    src_sram_write_n = 3'b011;
    src_sram_hiaddr  = {6'h2A, 6'h11, 6'h05};

    repeat (2) tick();
    mrst_n = 1'b1;
    tick();

    // Reset state
    do_read("reset_read", 8'h00);
    chk_busy("reset_busy", 1'b0);
    chk_out("reset_out_src0", exp_src(0));
    sb_push("reset_hiaddr", 32'h05);
    sb_check({26'd0, sram_hiaddr});

    // Switch to source 2 with the bus idle
    do_write(8'h02);
    chk_busy("sw_busy_e0", 1'b1);
    chk_out("sw_wait_old", exp_src(0));
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_busy($sformatf("sw_busy_e%0d", k), 1'b1);
      chk_out($sformatf("sw_blank_e%0d", k), exp_blank(6'h05));
    end
    tick();
    chk_busy("sw_busy_done", 1'b0);
    chk_out("sw_out_src2", exp_src(2));
    do_read("sw_read", 8'h02);

    // Bus busy: change waits
    cpu_mreq_n = 1'b0;
    do_write(8'h01);
    for (int k = 0; k < 10; k++) begin
      chk_busy($sformatf("bw_busy_%0d", k), 1'b1);
      chk_out($sformatf("bw_old_%0d", k), exp_src(2));
      tick();
    end
    do_read("bw_read_busybit", 8'h22);
    cpu_mreq_n = 1'b1;
    tick();
    chk_out("bw_blank_first", exp_blank(6'h2A));
    repeat (3) tick();
    chk_out("bw_blank_last", exp_blank(6'h2A));
    tick();
    chk_busy("bw_busy_done", 1'b0);
    chk_out("bw_out_src1", exp_src(1));

    // Invalid select keeps sel
    do_write(8'h03);
    repeat (5) tick();
    do_read("inv_read", 8'h01);
    // Lock
    do_write(8'h81);
    repeat (5) tick();
    do_read("lock_read", 8'h81);
    do_write(8'h02);
    chk_busy("lock_ignored_busy", 1'b0);
    repeat (5) tick();
    do_read("lock_read2", 8'h81);
    chk_out("lock_out_src1", exp_src(1));

    // Reset clears lock; then overlay with sel=2
    mrst_n = 1'b0;
    tick();
    mrst_n = 1'b1;
    tick();
    do_write(8'h42);
    repeat (5) tick();
    do_read("ovl_read", 8'h42);
    chk_out("ovl_inactive", exp_src(2));
    src_active = 3'b001;
    #1;
    chk_out("ovl_active", exp_src(0));
    src_active = 3'b000;
    #1;
    chk_out("ovl_back", exp_src(2));

    // Override during SETTLE
    do_write(8'h01);
    tick();
    chk_out("ovr_settle_blank", exp_blank(6'h2A));
    allramplus3 = 1'b1;
    #1;
    chk_out("ovr_plus3", exp_blank(6'b110000));
    chk_busy("ovr_busy", 1'b1);
    allramplus3 = 1'b0;
    repeat (4) tick();
    chk_busy("ovr_done", 1'b0);
    do_read("ovr_read", 8'h01);
    chk_out("ovr_out_src1", exp_src(1));

    // Reset mid-WAIT
    cpu_mreq_n = 1'b0;
    do_write(8'h02);
    chk_busy("rst_wait_busy", 1'b1);
    tick();
    mrst_n = 1'b0;
    #1;
    chk_busy("rst_busy_clear", 1'b0);
    do_read("rst_read", 8'h00);
    chk_out("rst_out_src0", exp_src(0));
    tick();
    mrst_n     = 1'b1;
    cpu_mreq_n = 1'b1;
    repeat (6) tick();
    chk_busy("rst_stays_idle", 1'b0);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
